// File: rtl/bmain_pkg.sv
// Shared bmain definitions: command encodings, line geometry and the refill FSM state type.
package bmain_pkg;

  localparam logic BMAIN_CMD_READ   = 1'b0;
  localparam logic BMAIN_CMD_WRITE  = 1'b1;
  localparam int   BMAIN_LINE_WORDS = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    DATA = 3'd2,
    EACK = 3'd3,
    RESP = 3'd4
  } refill_state_t;

endpackage

// File: rtl/bmain_refill.sv
// bmain read initiator: one read command per client line request, collects the
// burst into a line buffer and returns the line or an error indication.
module bmain_refill
  import bmain_pkg::*;
#(
  parameter int LINE_WORDS = BMAIN_LINE_WORDS,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk_core,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [23:0]             req_addr,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_error,
  output logic [32*LINE_WORDS-1:0] resp_data,
  output logic                    refill_cvalid,
  input  logic                    bmain_cready,
  output logic                    refill_cmd,
  output logic [25:0]             refill_addr,
  input  logic                    bmain_rvalid,
  output logic                    refill_rready,
  input  logic                    bmain_rlast,
  input  logic [31:0]             bmain_rdata,
  input  logic                    bmain_error,
  output logic                    refill_eack
);

  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(TIMEOUT - 1);

  refill_state_t     state_r;
  logic [BEAT_W-1:0] beat_r;
  logic [TMO_W-1:0]  tmo_r;
  logic              err_r;
  logic              req_ready_r;
  logic              cvalid_r;
  logic              rready_r;
  logic              eack_r;
  logic              resp_valid_r;
  logic              resp_error_r;
  logic [25:0]       addr_r;
  logic [31:0]       line_r [LINE_WORDS];

  logic beat_hs_s;
  logic last_beat_s;
  logic proto_err_s;
  logic burst_end_s;
  logic tmo_exp_s;

  // Beat handshake decode and rlast protocol check for the beat on the bus
  always_comb begin
    beat_hs_s   = (state_r == DATA) && bmain_rvalid && rready_r;
    last_beat_s = (beat_r == LAST_BEAT);
    proto_err_s = last_beat_s ? !bmain_rlast : bmain_rlast;
    burst_end_s = last_beat_s || bmain_rlast;
    tmo_exp_s   = (tmo_r == {TMO_W{1'b0}});
  end

  // Refill FSM with registered handshake outputs
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      req_ready_r  <= 1'b1;
      cvalid_r     <= 1'b0;
      rready_r     <= 1'b0;
      eack_r       <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      err_r        <= 1'b0;
      beat_r       <= {BEAT_W{1'b0}};
      tmo_r        <= {TMO_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            req_ready_r <= 1'b0;
            cvalid_r    <= 1'b1;
            beat_r      <= {BEAT_W{1'b0}};
            err_r       <= 1'b0;
            tmo_r       <= TMO_LOAD;
            state_r     <= CMD;
          end
        end
        CMD: begin
          if (bmain_error) begin
            cvalid_r <= 1'b0;
            err_r    <= 1'b1;
            eack_r   <= 1'b1;
            state_r  <= EACK;
          end else if (bmain_cready) begin
            cvalid_r <= 1'b0;
            rready_r <= 1'b1;
            tmo_r    <= TMO_LOAD;
            state_r  <= DATA;
          end else if (tmo_exp_s) begin
            // Timeout abandons the command without an error acknowledge
            cvalid_r     <= 1'b0;
            err_r        <= 1'b1;
            resp_valid_r <= 1'b1;
            resp_error_r <= 1'b1;
            state_r      <= RESP;
          end else begin
            tmo_r <= tmo_r - TMO_W'(1);
          end
        end
        DATA: begin
          if (bmain_error) begin
            rready_r <= 1'b0;
            err_r    <= 1'b1;
            eack_r   <= 1'b1;
            state_r  <= EACK;
          end else if (beat_hs_s) begin
            beat_r <= beat_r + BEAT_W'(1);
            tmo_r  <= TMO_LOAD;
            if (burst_end_s) begin
              rready_r     <= 1'b0;
              err_r        <= err_r | proto_err_s;
              resp_valid_r <= 1'b1;
              resp_error_r <= err_r | proto_err_s;
              state_r      <= RESP;
            end
          end else if (tmo_exp_s) begin
            rready_r     <= 1'b0;
            err_r        <= 1'b1;
            resp_valid_r <= 1'b1;
            resp_error_r <= 1'b1;
            state_r      <= RESP;
          end else begin
            tmo_r <= tmo_r - TMO_W'(1);
          end
        end
        EACK: begin
          eack_r       <= 1'b0;
          resp_valid_r <= 1'b1;
          resp_error_r <= err_r;
          state_r      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_error_r <= 1'b0;
            req_ready_r  <= 1'b1;
            state_r      <= IDLE;
          end
        end
        default: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          cvalid_r     <= 1'b0;
          rready_r     <= 1'b0;
          eack_r       <= 1'b0;
          resp_valid_r <= 1'b0;
          resp_error_r <= 1'b0;
        end
      endcase
    end
  end

  // Command address and line buffer; contents are don't-care after reset
  always_ff @(posedge clk_core) begin
    if ((state_r == IDLE) && req_valid) begin
      addr_r <= {req_addr, 2'b00};
    end
    if (beat_hs_s && !bmain_error) begin
      line_r[beat_r] <= bmain_rdata;
    end
  end

  // Flatten the line buffer, word i in bits [32i+31:32i]
  always_comb begin
    resp_data = {(32*LINE_WORDS){1'b0}};
    for (int i = 0; i < LINE_WORDS; i++) begin
      resp_data[32*i +: 32] = line_r[i];
    end
  end

  assign req_ready     = req_ready_r;
  assign refill_cvalid = cvalid_r;
  assign refill_rready = rready_r;
  assign refill_eack   = eack_r;
  assign resp_valid    = resp_valid_r;
  assign resp_error    = resp_error_r;
  assign refill_addr   = addr_r;
  assign refill_cmd    = BMAIN_CMD_READ;

endmodule

// File: tb/tb_bmain_refill.sv
// Self-checking bench for bmain_refill: directed table, reset-mid-burst sequence
// and randomized bursts checked against a line-level reference model.
module tb_bmain_refill;

  logic         clk_core;
  logic         reset_n;
  logic         req_valid;
  logic         req_ready;
  logic [23:0]  req_addr;
  logic         resp_valid;
  logic         resp_ready;
  logic         resp_error;
  logic [127:0] resp_data;
  logic         refill_cvalid;
  logic         bmain_cready;
  logic         refill_cmd;
  logic [25:0]  refill_addr;
  logic         bmain_rvalid;
  logic         refill_rready;
  logic         bmain_rlast;
  logic [31:0]  bmain_rdata;
  logic         bmain_error;
  logic         refill_eack;

  int n_cmp;
  int n_fail;
  int eack_total;

  bmain_refill #(.LINE_WORDS(4), .TIMEOUT(16)) dut (
    .clk_core(clk_core), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_error(resp_error),
    .resp_data(resp_data),
    .refill_cvalid(refill_cvalid), .bmain_cready(bmain_cready),
    .refill_cmd(refill_cmd), .refill_addr(refill_addr),
    .bmain_rvalid(bmain_rvalid), .refill_rready(refill_rready),
    .bmain_rlast(bmain_rlast), .bmain_rdata(bmain_rdata),
    .bmain_error(bmain_error), .refill_eack(refill_eack)
  );

  initial clk_core = 1'b0;
  always #5 clk_core = ~clk_core;

  always @(posedge clk_core) begin
    if (refill_eack === 1'b1) eack_total <= eack_total + 1;
  end

  typedef struct {
    logic [23:0]  addr;
    int           cdly;
    int           gap;
    logic [127:0] dat;
    int           rlast_at;   // beat carrying rlast; 4 = never
    int           err_at;     // bmain_error raised before this beat; 9 = never
    bit           tmo;        // no beats after the command handshake
    logic [25:0]  exp_addr;
    bit           exp_err;
    int           exp_words;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Line-level outcome: how many words land and whether the response is an error
  function automatic void ref_model(input int rlast_at, input int err_at,
                                    output bit e, output int words);
    int end_b;
    end_b = (rlast_at < 3) ? rlast_at : 3;
    if (err_at <= end_b) begin
      e = 1'b1;
      words = err_at;
    end else begin
      words = end_b + 1;
      e = (rlast_at != 3);
    end
  endfunction

  task automatic run_txn(input vec_t v);
    logic [127:0] mask;
    bit stable;
    bit injected;
    int n;
    int eack_start;
    eack_start = eack_total;
    injected = 1'b0;
    req_addr = v.addr;
    req_valid = 1'b1;
    check("req_ready_idle", {127'd0, req_ready}, 128'd1);
    @(posedge clk_core); #1;
    req_valid = 1'b0;
    check("cvalid_rise", {127'd0, refill_cvalid}, 128'd1);
    check("cmd_addr", {102'd0, refill_addr}, {102'd0, v.exp_addr});
    check("cmd_read", {127'd0, refill_cmd}, 128'd0);
    stable = 1'b1;
    for (int c = 0; c < v.cdly; c++) begin
      @(posedge clk_core); #1;
      if (refill_cvalid !== 1'b1 || refill_addr !== v.exp_addr) stable = 1'b0;
    end
    check("cmd_stable", {127'd0, stable}, 128'd1);
    bmain_cready = 1'b1;
    @(posedge clk_core); #1;
    bmain_cready = 1'b0;
    check("cvalid_drop", {127'd0, refill_cvalid}, 128'd0);
    if (!v.tmo) begin
      for (int b = 0; b < 4; b++) begin
        if (b > 0) begin
          repeat (v.gap) begin @(posedge clk_core); #1; end
        end
        if (v.err_at == b) begin
          injected = 1'b1;
          bmain_error = 1'b1;
          @(posedge clk_core); #1;
          bmain_error = 1'b0;
          check("eack_high", {127'd0, refill_eack}, 128'd1);
          check("resp_wait_eack", {127'd0, resp_valid}, 128'd0);
          @(posedge clk_core); #1;
          check("eack_low", {127'd0, refill_eack}, 128'd0);
          break;
        end
        check("rready", {127'd0, refill_rready}, 128'd1);
        bmain_rvalid = 1'b1;
        bmain_rdata  = v.dat[32*b +: 32];
        bmain_rlast  = (b == v.rlast_at);
        @(posedge clk_core); #1;
        bmain_rvalid = 1'b0;
        bmain_rlast  = 1'b0;
        if (b == 3 || b == v.rlast_at) break;
      end
      check("resp_valid_latency", {127'd0, resp_valid}, 128'd1);
    end else begin
      n = 0;
      while (resp_valid !== 1'b1 && n < 64) begin
        @(posedge clk_core); #1;
        n++;
      end
      check("timeout_cycles", n, 128'd16);
    end
    check("eack_count", eack_total - eack_start, {127'd0, injected});
    check("resp_error", {127'd0, resp_error}, {127'd0, v.exp_err});
    mask = 128'd0;
    for (int w = 0; w < 4; w++) begin
      if (w < v.exp_words) mask[32*w +: 32] = 32'hFFFF_FFFF;
    end
    check("resp_data", resp_data & mask, v.dat & mask);
    resp_ready = 1'b1;
    @(posedge clk_core); #1;
    resp_ready = 1'b0;
    check("resp_drop", {127'd0, resp_valid}, 128'd0);
    check("req_ready_back", {127'd0, req_ready}, 128'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"},  {127'd0, req_ready},     128'd1);
    check({tag, "_cvalid"},     {127'd0, refill_cvalid}, 128'd0);
    check({tag, "_rready"},     {127'd0, refill_rready}, 128'd0);
    check({tag, "_eack"},       {127'd0, refill_eack},   128'd0);
    check({tag, "_resp_valid"}, {127'd0, resp_valid},    128'd0);
    check({tag, "_resp_error"}, {127'd0, resp_error},    128'd0);
    check({tag, "_cmd"},        {127'd0, refill_cmd},    128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t rv;
    bit e;
    int words;
    n_cmp = 0; n_fail = 0; eack_total = 0;
    reset_n = 1'b0; req_valid = 1'b0; req_addr = 24'h0; resp_ready = 1'b0;
    bmain_cready = 1'b0; bmain_rvalid = 1'b0; bmain_rlast = 1'b0;
    bmain_rdata = 32'h0; bmain_error = 1'b0;

    tbl[0] = '{24'h000010, 0, 0, 128'h44444444_33333333_22222222_11111111,
               3, 9, 1'b0, 26'h0000040, 1'b0, 4};
    tbl[1] = '{24'hABCDEF, 5, 3, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF,
               3, 9, 1'b0, 26'h2AF37BC, 1'b0, 4};
    tbl[2] = '{24'h000123, 1, 0, 128'hA4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1,
               3, 2, 1'b0, 26'h000048C, 1'b1, 2};
    tbl[3] = '{24'h0F0F0F, 0, 1, 128'hB4B4B4B4_B3B3B3B3_B2B2B2B2_B1B1B1B1,
               2, 9, 1'b0, 26'h03C3C3C, 1'b1, 3};
    tbl[4] = '{24'h800000, 0, 0, 128'hC4C4C4C4_C3C3C3C3_C2C2C2C2_C1C1C1C1,
               4, 9, 1'b0, 26'h2000000, 1'b1, 4};
    tbl[5] = '{24'h00FFFF, 2, 0, 128'h0,
               3, 9, 1'b1, 26'h003FFFC, 1'b1, 0};

    repeat (3) @(posedge clk_core);
    #1;
    check_reset_values("reset");
    reset_n = 1'b1;
    @(posedge clk_core); #1;

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);

    // Reset in the middle of a burst, after two beats
    req_addr = 24'h123456; req_valid = 1'b1;
    @(posedge clk_core); #1;
    req_valid = 1'b0; bmain_cready = 1'b1;
    @(posedge clk_core); #1;
    bmain_cready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bmain_rvalid = 1'b1; bmain_rdata = 32'h5555_0000 + b; bmain_rlast = 1'b0;
      @(posedge clk_core); #1;
      bmain_rvalid = 1'b0;
    end
    check("mid_burst_rready", {127'd0, refill_rready}, 128'd1);
    reset_n = 1'b0;
    @(posedge clk_core); #1;
    check_reset_values("midreset");
    reset_n = 1'b1;
    @(posedge clk_core); #1;
    run_txn(tbl[0]);

    for (int r = 0; r < 25; r++) begin
      rv.addr = 24'($urandom);
      rv.cdly = $urandom_range(0, 5);
      rv.gap  = $urandom_range(0, 5);
      rv.dat  = {$urandom, $urandom, $urandom, $urandom};
      rv.rlast_at = ($urandom_range(0, 9) < 7) ? 3 : $urandom_range(0, 4);
      rv.err_at   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 9;
      rv.tmo = 1'b0;
      rv.exp_addr = {rv.addr, 2'b00};
      ref_model(rv.rlast_at, rv.err_at, e, words);
      rv.exp_err = e;
      rv.exp_words = words;
      run_txn(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
